// File: rtl/alu_frame_ctrl.sv
// Framed request/response sequencer between the UART FIFOs and a combinational ALU.
// Define ALU_FRAME_CHECKSUM_EN to append a checksum byte to both request and response frames.
module alu_frame_ctrl #(
    parameter int unsigned     DBIT     = 8,
    parameter int unsigned     OP_W     = 6,
    parameter int unsigned     TIMEOUT  = 50000,
    parameter int unsigned     TO_BITS  = 16,
    parameter logic [DBIT-1:0] SYNC_REQ = 8'hA5,
    parameter logic [DBIT-1:0] SYNC_RSP = 8'h5A
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_empty,
    input  logic [DBIT-1:0] r_data,
    output logic            rd_uart,
    input  logic            tx_full,
    output logic [DBIT-1:0] w_data,
    output logic            wr_uart,
    output logic [DBIT-1:0] op_a,
    output logic [DBIT-1:0] op_b,
    output logic [OP_W-1:0] op_code,
    input  logic [DBIT-1:0] alu_result,
    output logic [DBIT-1:0] last_result,
    output logic            busy,
    output logic [7:0]      frame_err_cnt
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_GET_OP    = 4'd1;
    localparam logic [3:0] S_GET_A     = 4'd2;
    localparam logic [3:0] S_GET_B     = 4'd3;
    localparam logic [3:0] S_EXEC      = 4'd5;
    localparam logic [3:0] S_SEND_SYNC = 4'd6;
    localparam logic [3:0] S_SEND_STAT = 4'd7;
    localparam logic [3:0] S_SEND_RES  = 4'd8;
`ifdef ALU_FRAME_CHECKSUM_EN
    localparam logic [3:0] S_GET_CK    = 4'd4;
    localparam logic [3:0] S_SEND_CK   = 4'd9;
    localparam logic [DBIT-1:0] ST_CK  = DBIT'(1);
`endif

    localparam logic [DBIT-1:0]    ST_OK   = '0;
    localparam logic [DBIT-1:0]    ST_OPC  = DBIT'(2);
    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT - 1);

    logic [3:0]         state_q,  state_d;
    logic [DBIT-1:0]    op_a_q,   op_a_d;
    logic [DBIT-1:0]    op_b_q,   op_b_d;
    logic [OP_W-1:0]    op_code_q, op_code_d;
    logic [DBIT-1:0]    status_q, status_d;
    logic [DBIT-1:0]    result_q, result_d;
    logic [DBIT-1:0]    last_q,   last_d;
    logic [DBIT-1:0]    w_data_q, w_data_d;
    logic [7:0]         err_q,    err_d;
    logic [TO_BITS-1:0] to_q,     to_d;
    logic               busy_q,   busy_d;
    logic               err_inc;
    logic               in_frame;
    logic               rd_c;
    logic               wr_c;
`ifdef ALU_FRAME_CHECKSUM_EN
    logic [DBIT-1:0]    ck_q,     ck_d;
`endif

    // Next-state, frame parsing, response sequencing and timeout
    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        op_code_d = op_code_q;
        status_d  = status_q;
        result_d  = result_q;
        last_d    = last_q;
        w_data_d  = w_data_q;
        to_d      = '0;
        err_inc   = 1'b0;
        rd_c      = 1'b0;
        wr_c      = 1'b0;
`ifdef ALU_FRAME_CHECKSUM_EN
        ck_d      = ck_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rx_empty) begin
                    rd_c = 1'b1;
                    if (r_data == SYNC_REQ) begin
                        state_d = S_GET_OP;
                    end
                end
            end
            S_GET_OP: begin
                if (!rx_empty) begin
                    rd_c      = 1'b1;
                    op_code_d = r_data[OP_W-1:0];
                    status_d  = (r_data[DBIT-1:OP_W] != '0) ? ST_OPC : ST_OK;
`ifdef ALU_FRAME_CHECKSUM_EN
                    ck_d      = r_data;
`endif
                    state_d   = S_GET_A;
                end
            end
            S_GET_A: begin
                if (!rx_empty) begin
                    rd_c    = 1'b1;
                    op_a_d  = r_data;
`ifdef ALU_FRAME_CHECKSUM_EN
                    ck_d    = ck_q ^ r_data;
`endif
                    state_d = S_GET_B;
                end
            end
            S_GET_B: begin
                if (!rx_empty) begin
                    rd_c    = 1'b1;
                    op_b_d  = r_data;
`ifdef ALU_FRAME_CHECKSUM_EN
                    ck_d    = ck_q ^ r_data;
                    state_d = S_GET_CK;
`else
                    state_d = S_EXEC;
`endif
                end
            end
`ifdef ALU_FRAME_CHECKSUM_EN
            S_GET_CK: begin
                if (!rx_empty) begin
                    rd_c = 1'b1;
                    // Checksum error overrides a bad-opcode flag
                    if (r_data != ck_q) begin
                        status_d = ST_CK;
                    end
                    state_d = S_EXEC;
                end
            end
`endif
            S_EXEC: begin
                if (status_q == ST_OK) begin
                    result_d = alu_result;
                    last_d   = alu_result;
                end else begin
                    result_d = '0;
                    err_inc  = 1'b1;
                end
                w_data_d = SYNC_RSP;
                state_d  = S_SEND_SYNC;
            end
            S_SEND_SYNC: begin
                if (!tx_full) begin
                    wr_c     = 1'b1;
                    w_data_d = status_q;
                    state_d  = S_SEND_STAT;
                end
            end
            S_SEND_STAT: begin
                if (!tx_full) begin
                    wr_c     = 1'b1;
                    w_data_d = result_q;
                    state_d  = S_SEND_RES;
                end
            end
            S_SEND_RES: begin
                if (!tx_full) begin
                    wr_c = 1'b1;
`ifdef ALU_FRAME_CHECKSUM_EN
                    w_data_d = status_q ^ result_q;
                    state_d  = S_SEND_CK;
`else
                    w_data_d = '0;
                    state_d  = S_IDLE;
`endif
                end
            end
`ifdef ALU_FRAME_CHECKSUM_EN
            S_SEND_CK: begin
                if (!tx_full) begin
                    wr_c     = 1'b1;
                    w_data_d = '0;
                    state_d  = S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef ALU_FRAME_CHECKSUM_EN
        in_frame = (state_q == S_GET_OP) || (state_q == S_GET_A) ||
                   (state_q == S_GET_B)  || (state_q == S_GET_CK);
`else
        in_frame = (state_q == S_GET_OP) || (state_q == S_GET_A) ||
                   (state_q == S_GET_B);
`endif
        // Inter-byte timeout abandons the partial frame without a response
        if (in_frame && rx_empty) begin
            if (to_q == TO_LAST) begin
                state_d = S_IDLE;
                err_inc = 1'b1;
            end else begin
                to_d = to_q + TO_BITS'(1);
            end
        end

        err_d   = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
        busy_d  = (state_d != S_IDLE);
        rd_uart = rd_c & ~reset;
        wr_uart = wr_c & ~reset;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_code_q <= '0;
            status_q  <= '0;
            result_q  <= '0;
            last_q    <= '0;
            w_data_q  <= '0;
            err_q     <= '0;
            to_q      <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            op_code_q <= op_code_d;
            status_q  <= status_d;
            result_q  <= result_d;
            last_q    <= last_d;
            w_data_q  <= w_data_d;
            err_q     <= err_d;
            to_q      <= to_d;
            busy_q    <= busy_d;
        end
    end

`ifdef ALU_FRAME_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ck_q <= '0;
        end else begin
            ck_q <= ck_d;
        end
    end
`endif

    assign op_a          = op_a_q;
    assign op_b          = op_b_q;
    assign op_code       = op_code_q;
    assign last_result   = last_q;
    assign w_data        = w_data_q;
    assign busy          = busy_q;
    assign frame_err_cnt = err_q;

endmodule
